pipe_hazard_ctl: RTL and testbench
==================================

Name: pipe_hazard_ctl

Overview:
Pipeline sequencing controller for the 5-stage 16-bit CPU (IF/ID/EX/MEM/WB). It generates the PC write enable, the per-stage pipeline-register enables and the flush signals. It handles load-use stalls, taken-branch squashes, multi-cycle memory freezes and the HLT drain sequence. It also keeps a saturating stall-cycle performance counter.

Parameters:
CNT_W, 16, width of the stall-cycle counter
DRAIN_CYC, 3, number of advancing cycles from HLT leaving ID until HLT occupies WB

Ports:
clk  in  1  system clock
rst_n  in  1  reset, asynchronous, active-low
id_src1  in  4  ID-stage source register 1
id_src2  in  4  ID-stage source register 2
id_uses_src1  in  1  ID instruction reads id_src1
id_uses_src2  in  1  ID instruction reads id_src2
id_is_hlt  in  1  ID instruction is HLT (opcode 4'b1111)
ex_is_load  in  1  EX instruction is LW (opcode 4'b1000)
ex_writereg  in  1  EX instruction writes the register file
ex_dst  in  4  EX destination register
branch_taken  in  1  EX resolved a taken branch or BR this cycle
mem_stall  in  1  a memory (I or D) is busy; the whole pipe must freeze
pc_en  out  1  PC register write enable
ifid_en  out  1  IF/ID enable
idex_en  out  1  ID/EX enable
exmem_en  out  1  EX/MEM enable
memwb_en  out  1  MEM/WB enable
flush_ifid  out  1  load a bubble into IF/ID
flush_idex  out  1  load a bubble into ID/EX
halted  out  1  processor halted
stall_cycles  out  CNT_W  saturating count of stall cycles

Behaviour:
- State is RUN, DRAIN or HALTED; drain_cnt is 2 bits. Reset (async) sets RUN, drain_cnt=0, stall_cycles=0.
- While rst_n=0, all enables, all flushes and halted are forced 0.
- Outputs are combinational from state and inputs, and are valid in the same cycle. State and counter update on the posedge clk.
- load_use = ex_is_load & ex_writereg & (ex_dst!=0) & ((id_uses_src1 & id_src1==ex_dst) | (id_uses_src2 & id_src2==ex_dst)).
- RUN priority, highest first:
  1. mem_stall: all five enables 0, no flush; state holds.
  2. branch_taken: all enables 1, flush_ifid=1, flush_idex=1. id_is_hlt and load_use are ignored because the ID instruction is squashed.
  3. load_use: pc_en=0, ifid_en=0, flush_idex=1, other enables 1. The stall is exactly 1 cycle; the next cycle the load is in MEM, and forwarding covers it.
  4. id_is_hlt: pc_en=0, flush_ifid=1, other enables 1; next state DRAIN with drain_cnt=DRAIN_CYC-1.
  5. Otherwise all enables 1, no flush.
- DRAIN:
  - pc_en=0, flush_ifid=1, other enables 1.
  - If mem_stall=1: all enables 0, no flush, drain_cnt holds.
  - Else if drain_cnt==0: next state HALTED.
  - Else drain_cnt decrements.
  - branch_taken and load_use cannot occur in DRAIN (only HLT or bubbles are past ID) and are ignored.
- HALTED: all enables 0, no flush, halted=1. Only reset exits.
- Timing: if HLT is in ID at cycle T with no stall, halted=1 from T+4 (HLT is in WB at T+3).
- stall_cycles increments by 1 on each cycle in RUN or DRAIN where mem_stall=1, or where load_use applies (priority 3 taken). It saturates at 2^CNT_W-1 and never wraps. It does not count in HALTED or during reset.
- Reset asserted mid-drain or mid-stall returns immediately to RUN with the counter cleared.

Test Plan:
- Load-use: ex_is_load=1, ex_writereg=1, ex_dst=3, id_src1=3, id_uses_src1=1 for 1 cycle -> pc_en=0, ifid_en=0, flush_idex=1 that cycle, stall_cycles 0->1; ex_dst=0 with the same sources -> no stall.
- Branch beats load-use: branch_taken=1 with load_use true and id_is_hlt=1 -> flush_ifid=1, flush_idex=1, pc_en=1; state stays RUN; stall_cycles unchanged.
- HLT drain: id_is_hlt=1 at T, no stalls -> pc_en=0 from T; flush_ifid=1 at T..T+3; halted=0 through T+3 and halted=1 from T+4 with all enables 0.
- Memory freeze during drain: mem_stall=1 for 2 cycles at T+2 -> all enables 0 on those cycles; halted first asserts at T+6; stall_cycles +2.
- Saturation: CNT_W=4, hold mem_stall=1 for 20 cycles -> stall_cycles reaches 15 and holds at 15.
- Async reset: assert rst_n=0 mid-cycle while in DRAIN -> immediately all enables 0 and halted=0. Release -> RUN with all enables 1 and stall_cycles=0.

Source files
------------

// File: rtl/pipe_hazard_ctl.sv
// ============================================================================
// Module   : pipe_hazard_ctl
// Purpose  : Pipeline sequencing for the 5-stage CPU: stalls, squashes,
//            memory freezes, HLT drain and a saturating stall-cycle counter.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module pipe_hazard_ctl #(
    parameter int CNT_W     = 16,
    parameter int DRAIN_CYC = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [3:0]       id_src1,
    input  logic [3:0]       id_src2,
    input  logic             id_uses_src1,
    input  logic             id_uses_src2,
    input  logic             id_is_hlt,
    input  logic             ex_is_load,
    input  logic             ex_writereg,
    input  logic [3:0]       ex_dst,
    input  logic             branch_taken,
    input  logic             mem_stall,
    output logic             pc_en,
    output logic             ifid_en,
    output logic             idex_en,
    output logic             exmem_en,
    output logic             memwb_en,
    output logic             flush_ifid,
    output logic             flush_idex,
    output logic             halted,
    output logic [CNT_W-1:0] stall_cycles
);

    typedef enum logic [1:0] {
        S_RUN    = 2'd0,
        S_DRAIN  = 2'd1,
        S_HALTED = 2'd2
    } state_t;

    localparam logic [1:0]       c_DRAIN_INIT = 2'(DRAIN_CYC - 1);
    localparam logic [CNT_W-1:0] c_CNT_MAX    = {CNT_W{1'b1}};

    state_t           r_state;
    state_t           w_state_nxt;
    logic [1:0]       r_drain_cnt;
    logic [1:0]       w_drain_cnt_nxt;
    logic [CNT_W-1:0] r_stall_cnt;

    logic w_load_use;
    logic w_count;
    logic w_pc_en;
    logic w_ifid_en;
    logic w_idex_en;
    logic w_exmem_en;
    logic w_memwb_en;
    logic w_flush_ifid;
    logic w_flush_idex;
    logic w_halted;

    assign w_load_use = ex_is_load & ex_writereg & (ex_dst != 4'd0) &
                        ((id_uses_src1 & (id_src1 == ex_dst)) |
                         (id_uses_src2 & (id_src2 == ex_dst)));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_RUN;
            r_drain_cnt <= 2'd0;
        end else begin
            r_state     <= w_state_nxt;
            r_drain_cnt <= w_drain_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_drain_cnt_nxt = r_drain_cnt;
        w_pc_en         = 1'b0;
        w_ifid_en       = 1'b0;
        w_idex_en       = 1'b0;
        w_exmem_en      = 1'b0;
        w_memwb_en      = 1'b0;
        w_flush_ifid    = 1'b0;
        w_flush_idex    = 1'b0;
        w_halted        = 1'b0;
        w_count         = 1'b0;
        case (r_state)
            S_RUN: begin
                if (mem_stall) begin
                    w_count = 1'b1;
                end else if (branch_taken) begin
                    // The ID instruction is squashed, so HLT/load-use there are moot
                    {w_pc_en, w_ifid_en, w_idex_en, w_exmem_en, w_memwb_en} = 5'b11111;
                    w_flush_ifid = 1'b1;
                    w_flush_idex = 1'b1;
                end else if (w_load_use) begin
                    {w_idex_en, w_exmem_en, w_memwb_en} = 3'b111;
                    w_flush_idex = 1'b1;
                    w_count      = 1'b1;
                end else if (id_is_hlt) begin
                    {w_ifid_en, w_idex_en, w_exmem_en, w_memwb_en} = 4'b1111;
                    w_flush_ifid    = 1'b1;
                    w_state_nxt     = S_DRAIN;
                    w_drain_cnt_nxt = c_DRAIN_INIT;
                end else begin
                    {w_pc_en, w_ifid_en, w_idex_en, w_exmem_en, w_memwb_en} = 5'b11111;
                end
            end
            S_DRAIN: begin
                if (mem_stall) begin
                    w_count = 1'b1;
                end else begin
                    {w_ifid_en, w_idex_en, w_exmem_en, w_memwb_en} = 4'b1111;
                    w_flush_ifid = 1'b1;
                    if (r_drain_cnt == 2'd0) begin
                        w_state_nxt = S_HALTED;
                    end else begin
                        w_drain_cnt_nxt = r_drain_cnt - 2'd1;
                    end
                end
            end
            S_HALTED: begin
                w_halted = 1'b1;
            end
            default: begin
                w_state_nxt = S_RUN;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stall_cnt <= '0;
        end else if (w_count && (r_stall_cnt != c_CNT_MAX)) begin
            r_stall_cnt <= r_stall_cnt + 1'b1;
        end
    end

    // Reset is asynchronous, so every control output is gated off while it is low
    assign pc_en        = rst_n & w_pc_en;
    assign ifid_en      = rst_n & w_ifid_en;
    assign idex_en      = rst_n & w_idex_en;
    assign exmem_en     = rst_n & w_exmem_en;
    assign memwb_en     = rst_n & w_memwb_en;
    assign flush_ifid   = rst_n & w_flush_ifid;
    assign flush_idex   = rst_n & w_flush_idex;
    assign halted       = rst_n & w_halted;
    assign stall_cycles = r_stall_cnt;

endmodule

`default_nettype wire

// File: tb/tb_pipe_hazard_ctl.sv
// ============================================================================
// Module   : tb_pipe_hazard_ctl
// Purpose  : Scoreboard bench for pipe_hazard_ctl, directed plus random.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_pipe_hazard_ctl;

    localparam int DRAIN_CYC = 3;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] id_src1, id_src2, ex_dst;
    logic       id_uses_src1, id_uses_src2, id_is_hlt;
    logic       ex_is_load, ex_writereg, branch_taken, mem_stall;

    logic       pc_en, ifid_en, idex_en, exmem_en, memwb_en;
    logic       flush_ifid, flush_idex, halted;
    logic [15:0] stall16;
    logic       pc_en4, ifid_en4, idex_en4, exmem_en4, memwb_en4;
    logic       flush_ifid4, flush_idex4, halted4;
    logic [3:0] stall4;

    always #5 clk = ~clk;

    pipe_hazard_ctl #(.CNT_W(16), .DRAIN_CYC(DRAIN_CYC)) dut (
        .clk(clk), .rst_n(rst_n),
        .id_src1(id_src1), .id_src2(id_src2),
        .id_uses_src1(id_uses_src1), .id_uses_src2(id_uses_src2),
        .id_is_hlt(id_is_hlt), .ex_is_load(ex_is_load),
        .ex_writereg(ex_writereg), .ex_dst(ex_dst),
        .branch_taken(branch_taken), .mem_stall(mem_stall),
        .pc_en(pc_en), .ifid_en(ifid_en), .idex_en(idex_en),
        .exmem_en(exmem_en), .memwb_en(memwb_en),
        .flush_ifid(flush_ifid), .flush_idex(flush_idex),
        .halted(halted), .stall_cycles(stall16)
    );

    pipe_hazard_ctl #(.CNT_W(4), .DRAIN_CYC(DRAIN_CYC)) dut4 (
        .clk(clk), .rst_n(rst_n),
        .id_src1(id_src1), .id_src2(id_src2),
        .id_uses_src1(id_uses_src1), .id_uses_src2(id_uses_src2),
        .id_is_hlt(id_is_hlt), .ex_is_load(ex_is_load),
        .ex_writereg(ex_writereg), .ex_dst(ex_dst),
        .branch_taken(branch_taken), .mem_stall(mem_stall),
        .pc_en(pc_en4), .ifid_en(ifid_en4), .idex_en(idex_en4),
        .exmem_en(exmem_en4), .memwb_en(memwb_en4),
        .flush_ifid(flush_ifid4), .flush_idex(flush_idex4),
        .halted(halted4), .stall_cycles(stall4)
    );

    typedef struct {
        logic [7:0] flags;  // {pc,ifid,idex,exmem,memwb,flush_ifid,flush_idex,halted}
        int         cnt16;
        int         cnt4;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    // Reference model: where the HLT sits in the pipe (0 = none, 2 = EX ... ),
    // whether the CPU has halted, and plain integer stall counters.
    int m_hlt_pos = 0;
    bit m_halted  = 1'b0;
    int m_cnt16   = 0;
    int m_cnt4    = 0;

    function automatic void model_count();
        if (m_cnt16 < 65535) m_cnt16++;
        if (m_cnt4 < 15) m_cnt4++;
    endfunction

    task automatic step(input logic rn, ms, bt, hlt, ld, wr,
                        input logic [3:0] dst, s1, s2, input logic u1, u2);
        exp_t e;
        bit   lu;
        @(posedge clk);
        #1;
        rst_n = rn; mem_stall = ms; branch_taken = bt; id_is_hlt = hlt;
        ex_is_load = ld; ex_writereg = wr; ex_dst = dst;
        id_src1 = s1; id_src2 = s2; id_uses_src1 = u1; id_uses_src2 = u2;
        lu = ld && wr && (dst != 0) && ((u1 && s1 == dst) || (u2 && s2 == dst));
        if (!rn) begin
            m_hlt_pos = 0; m_halted = 1'b0; m_cnt16 = 0; m_cnt4 = 0;
            e.flags = 8'b0;
        end else if (m_halted) begin
            e.flags = 8'b0000_0001;
        end else if (ms) begin
            e.flags = 8'b0;
        end else if (m_hlt_pos != 0) begin
            e.flags = 8'b0111_1100;
        end else if (bt) begin
            e.flags = 8'b1111_1110;
        end else if (lu) begin
            e.flags = 8'b0011_1010;
        end else if (hlt) begin
            e.flags = 8'b0111_1100;
        end else begin
            e.flags = 8'b1111_1000;
        end
        e.cnt16 = m_cnt16;
        e.cnt4  = m_cnt4;
        exp_q.push_back(e);
        // advance the model to the state seen after the coming edge
        if (rn && !m_halted) begin
            if (ms) begin
                model_count();
            end else if (m_hlt_pos != 0) begin
                m_hlt_pos++;
                if (m_hlt_pos == DRAIN_CYC + 2) begin
                    m_halted  = 1'b1;
                    m_hlt_pos = 0;
                end
            end else if (bt) begin
                // squash only
            end else if (lu) begin
                model_count();
            end else if (hlt) begin
                m_hlt_pos = 2;
            end
        end
    endtask

    task automatic idle(input logic rn, input logic ms);
        step(rn, ms, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 4'd0, 4'd0, 1'b0, 1'b0);
    endtask

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            logic [7:0] a, a4;
            e  = exp_q.pop_front();
            a  = {pc_en, ifid_en, idex_en, exmem_en, memwb_en, flush_ifid, flush_idex, halted};
            a4 = {pc_en4, ifid_en4, idex_en4, exmem_en4, memwb_en4, flush_ifid4, flush_idex4, halted4};
            n_checks++;
            if (a !== e.flags) begin
                n_fail++;
                $display("FAIL ctl16 @%0t: got %b want %b", $time, a, e.flags);
            end
            n_checks++;
            if (a4 !== e.flags) begin
                n_fail++;
                $display("FAIL ctl4 @%0t: got %b want %b", $time, a4, e.flags);
            end
            n_checks++;
            if (stall16 !== 16'(e.cnt16)) begin
                n_fail++;
                $display("FAIL stall16 @%0t: got %0d want %0d", $time, stall16, e.cnt16);
            end
            n_checks++;
            if (stall4 !== 4'(e.cnt4)) begin
                n_fail++;
                $display("FAIL stall4 @%0t: got %0d want %0d", $time, stall4, e.cnt4);
            end
        end
    end

    initial begin
        rst_n = 1'b0; mem_stall = 1'b0; branch_taken = 1'b0; id_is_hlt = 1'b0;
        ex_is_load = 1'b0; ex_writereg = 1'b0; ex_dst = 4'd0;
        id_src1 = 4'd0; id_src2 = 4'd0; id_uses_src1 = 1'b0; id_uses_src2 = 1'b0;

        idle(1'b0, 1'b0);
        idle(1'b0, 1'b0);
        idle(1'b1, 1'b0);

        // load-use on src1, then same sources against r0
        step(1, 0, 0, 0, 1, 1, 4'd3, 4'd3, 4'd5, 1, 0);
        step(1, 0, 0, 0, 1, 1, 4'd0, 4'd0, 4'd0, 1, 1);
        // load-use on src2 only
        step(1, 0, 0, 0, 1, 1, 4'd7, 4'd1, 4'd7, 1, 1);
        // branch beats load-use and HLT
        step(1, 0, 1, 1, 1, 1, 4'd3, 4'd3, 4'd5, 1, 0);
        idle(1'b1, 1'b0);

        // clean HLT drain
        step(1, 0, 0, 1, 0, 0, 4'd0, 4'd0, 4'd0, 0, 0);
        repeat (6) idle(1'b1, 1'b0);

        // HLT drain with a 2-cycle memory freeze at T+2
        idle(1'b0, 1'b0);
        step(1, 0, 0, 1, 0, 0, 4'd0, 4'd0, 4'd0, 0, 0);
        idle(1'b1, 1'b0);
        idle(1'b1, 1'b1);
        idle(1'b1, 1'b1);
        repeat (5) idle(1'b1, 1'b0);

        // saturation of the 4-bit counter
        idle(1'b0, 1'b0);
        repeat (20) idle(1'b1, 1'b1);
        repeat (2) idle(1'b1, 1'b0);

        // reset mid-drain
        step(1, 0, 0, 1, 0, 0, 4'd0, 4'd0, 4'd0, 0, 0);
        idle(1'b1, 1'b0);
        idle(1'b0, 1'b0);
        idle(1'b1, 1'b0);
        idle(1'b1, 1'b0);

        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            logic rn;
            rn = ($urandom_range(0, m_halted ? 6 : 250) != 0);
            step(rn,
                 ($urandom_range(0, 4) == 0),
                 ($urandom_range(0, 5) == 0),
                 ($urandom_range(0, 25) == 0),
                 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 1)),
                 4'($urandom_range(0, 3)),
                 4'($urandom_range(0, 3)),
                 4'($urandom_range(0, 3)),
                 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 1)));
        end

        @(posedge clk);
        @(posedge clk);
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain_q: got %0d entries want 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
